// File: rtl/crc32_lut.sv
// Registered CRC-32 lookup table: data = (addr(x) * x^(XN+32)) mod P(x), one cycle after an enabled edge.
// Table contents are fixed at elaboration; instances are XORed together outside to build wide CRC engines.
module crc32_lut #(
  parameter int          XN   = 0,
  parameter logic [31:0] POLY = 32'h04C11DB7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic [7:0]  addr,
  output logic [31:0] data
);

  // Multiply by x modulo P(x), x^32 term implied
  function automatic logic [31:0] mul_x(input logic [31:0] v);
    return {v[30:0], 1'b0} ^ (v[31] ? POLY : 32'h0);
  endfunction

  function automatic logic [255:0][31:0] build_table();
    logic [7:0][31:0]   basis;
    logic [255:0][31:0] tbl;
    logic [31:0]        r;
    logic [7:0]         a_bits;
    r = 32'h1;
    for (int i = 0; i < XN + 32; i++) r = mul_x(r);
    for (int k = 0; k < 8; k++) begin
      basis[k] = r;
      r = mul_x(r);
    end
    // Linearity lets every entry be the XOR of the basis terms selected by its set bits
    for (int a = 0; a < 256; a++) begin
      a_bits = a[7:0];
      tbl[a] = '0;
      for (int k = 0; k < 8; k++) begin
        if (a_bits[k]) tbl[a] = tbl[a] ^ basis[k];
      end
    end
    return tbl;
  endfunction

  localparam logic [255:0][31:0] LUT = build_table();

  logic [31:0] data_q = '0;

  always_ff @(posedge clk) begin
    if (!rst_n) data_q <= '0;
    else if (ce) data_q <= LUT[addr];
  end

  assign data = data_q;

endmodule

// File: tb/tb_crc32_lut.sv
// Scoreboard bench for crc32_lut: several XN instances share one stimulus stream and are
// compared against a bit-serial polynomial model plus a handful of known constants.
module tb_crc32_lut;

  localparam int          NI   = 7;
  localparam int          XN_LIST [NI] = '{0, 1, 7, 8, 32, 56, 88};
  localparam logic [31:0] POLY = 32'h04C11DB7;

  typedef struct {
    string              tag;
    logic [NI-1:0][31:0] exp;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ce = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] dout [NI];

  sb_item_t            sb_q [$];
  logic [NI-1:0][31:0] exp_state = '0;
  int                  total = 0;
  int                  bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    crc32_lut #(.XN(XN_LIST[g]), .POLY(POLY)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .addr  (addr),
      .data  (dout[g])
    );
  end

  // Bit-serial reference: start from A(x), multiply by x one step at a time
  function automatic logic [31:0] model_crc(input int xn, input logic [7:0] a);
    logic [31:0] r;
    r = {24'h0, a};
    for (int i = 0; i < xn + 32; i++) r = {r[30:0], 1'b0} ^ (r[31] ? POLY : 32'h0);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic [7:0] a, input string tag);
    sb_item_t item;
    @(negedge clk);
    rst_n = r;
    ce    = c;
    addr  = a;
    for (int i = 0; i < NI; i++) begin
      if (!r)     exp_state[i] = '0;
      else if (c) exp_state[i] = model_crc(XN_LIST[i], a);
    end
    item.tag = tag;
    item.exp = exp_state;
    sb_q.push_back(item);
    @(posedge clk);
    #1;
    item = sb_q.pop_front();
    for (int i = 0; i < NI; i++)
      checkOutput($sformatf("%s_xn%0d", item.tag, XN_LIST[i]), dout[i], item.exp[i]);
  endtask

  initial begin
    #1;
    for (int i = 0; i < NI; i++) checkOutput($sformatf("powerup_xn%0d", XN_LIST[i]), dout[i], 32'h0);

    applyStimulus(1'b0, 1'b1, 8'hFF, "reset_ce");
    applyStimulus(1'b0, 1'b0, 8'h12, "reset");

    applyStimulus(1'b1, 1'b1, 8'h00, "a00");
    checkOutput("xn0_a00_const", dout[0], 32'h00000000);
    applyStimulus(1'b1, 1'b1, 8'h01, "a01");
    checkOutput("xn0_a01_const", dout[0], 32'h04C11DB7);
    checkOutput("xn1_a01_const", dout[1], 32'h09823B6E);
    checkOutput("xn7_a01_const", dout[2], 32'h690CE0EE);
    applyStimulus(1'b1, 1'b1, 8'h02, "a02");
    checkOutput("xn0_a02_const", dout[0], 32'h09823B6E);
    applyStimulus(1'b1, 1'b1, 8'h80, "a80");
    checkOutput("xn0_a80_const", dout[0], 32'h690CE0EE);

    for (int a = 0; a < 256; a++) applyStimulus(1'b1, 1'b1, a[7:0], "sweep");

    applyStimulus(1'b1, 1'b1, 8'h5A, "pre_hold");
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 8'hA5 ^ k[7:0], "hold");
    applyStimulus(1'b1, 1'b1, 8'hC3, "reenable");

    applyStimulus(1'b1, 1'b1, 8'h3C, "pre_rst");
    applyStimulus(1'b0, 1'b1, 8'hFF, "mid_rst");
    for (int i = 0; i < NI; i++) checkOutput($sformatf("mid_rst_zero_xn%0d", XN_LIST[i]), dout[i], 32'h0);
    applyStimulus(1'b1, 1'b1, 8'hFF, "post_rst");

    for (int k = 0; k < 60; k++)
      applyStimulus(($urandom_range(0, 15) != 0), $urandom_range(0, 1) == 1,
                    8'($urandom_range(0, 255)), "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
